// File: rtl/hs_sync_rx_if.sv
// Handshake bundle for hs_sync_rx: foreign-domain req/ack/data plus the downstream
// valid/ready word port. master = foreign sender and consumer side, slave = receiver.
interface hs_sync_rx_if #(
    parameter int unsigned N = 8
);
    logic         req_async;
    logic [N-1:0] data_async;
    logic         ack;
    logic [N-1:0] data_out;
    logic         valid_out;
    logic         ready_in;

    modport master (
        output req_async,
        output data_async,
        output ready_in,
        input  ack,
        input  data_out,
        input  valid_out
    );

    modport slave (
        input  req_async,
        input  data_async,
        input  ready_in,
        output ack,
        output data_out,
        output valid_out
    );
endinterface

// File: rtl/hs_sync_rx.sv
// 4-phase handshake receiver: synchronizes req_async, captures the bundled data once per
// request and presents it on a valid/ready port; flags request drops during HOLD.
module hs_sync_rx #(
    parameter int unsigned N           = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    hs_sync_rx_if.slave      bus,
    output logic [7:0]       word_cnt,
    output logic             proto_err,
    input  logic             err_clr
);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StAck
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_q, ack_d;
    logic                   valid_q, valid_d;
    logic [N-1:0]           data_q, data_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   err_set;
    logic                   req_s;

    // Only the last synchronizer stage is visible to the FSM.
    assign req_s  = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.req_async};

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_s && ena) begin
                    state_d = StHold;
                    data_d  = bus.data_async;
                    valid_d = 1'b1;
                end
            end
            StHold: begin
                // Early req drop is flagged but the held word is still delivered.
                if (!req_s) begin
                    err_set = 1'b1;
                end
                if (bus.ready_in) begin
                    state_d = StAck;
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            StAck: begin
                if (!req_s) begin
                    state_d = StIdle;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                ack_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sync_q  <= '0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign word_cnt      = cnt_q;
    assign proto_err     = err_q;

endmodule

// File: doc/hs_sync_rx.md
HS_SYNC_RX -- requirements
Module: hs_sync_rx

Interface
REQ-001 Parameter N, default 8: data bus width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4: depth of the req synchronizer flip-flop chain.
REQ-003 clk  input  1: single destination-domain clock; all state updates on its rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 ena  input  1: block enable; low blocks starting a new transfer only.
REQ-006 req_async  input  1: 4-phase request from the foreign clock domain, asynchronous to clk.
REQ-007 data_async  input  N: bundled data from the foreign domain, stable while req_async is high.
REQ-008 ack  output  1: 4-phase acknowledge back to the foreign domain, driven directly from a flip-flop.
REQ-009 data_out  output  N: registered captured word.
REQ-010 valid_out  output  1: data_out holds an unconsumed word.
REQ-011 ready_in  input  1: downstream consumer can accept data_out.
REQ-012 word_cnt  output  8: count of words accepted downstream.
REQ-013 proto_err  output  1: sticky handshake-violation flag.
REQ-014 err_clr  input  1: synchronous clear of proto_err.

Function
REQ-015 req_async SHALL enter only through a SYNC_STAGES-deep flip-flop chain; the FSM reads only its last stage, req_s.
REQ-016 data_async SHALL NOT be synchronized; it is sampled only in the cycle the FSM leaves IDLE.
REQ-017 The FSM SHALL have exactly three states: IDLE, HOLD, ACK.
REQ-018 IDLE -> HOLD when req_s=1 and ena=1; on that edge: data_out <= data_async, valid_out <= 1.
REQ-019 IDLE with req_s=1 and ena=0 SHALL remain in IDLE, with no capture and ack=0.
REQ-020 HOLD: valid_out=1 and data_out stable; when valid_out=1 and ready_in=1 on an edge -> ACK, valid_out <= 0, ack <= 1, word_cnt increments.
REQ-021 ACK: ack stays 1 until req_s=0 is sampled; then ack <= 0 and the FSM returns to IDLE.
REQ-022 A new capture SHALL NOT occur before req_s has been seen low in ACK, so one req pulse yields exactly one word.
REQ-023 Latency: valid_out SHALL rise on the (SYNC_STAGES+1)-th rising edge counted from the first edge that samples req_async high (ena=1, FSM in IDLE).
REQ-024 ready_in already high when valid_out rises: the accept edge is the next edge, so valid_out is high for exactly 1 cycle.
REQ-025 word_cnt SHALL wrap from 255 to 0 with no flag.
REQ-026 req_s=0 sampled while in HOLD SHALL set proto_err.
- The held word is kept and delivered normally; no abort.
- ACK is still entered on accept and exits on the next edge.
REQ-027 proto_err SHALL remain set until err_clr=1 on an edge or rst.
- If a new violation coincides with err_clr on the same edge, set wins.
REQ-028 ena deasserted in HOLD or ACK SHALL NOT affect the transfer in progress.

Reset
REQ-029 While rst=1, asynchronously:
- all synchronizer stages = 0;
- FSM = IDLE;
- ack = 0, valid_out = 0, data_out = 0;
- word_cnt = 0, proto_err = 0.
REQ-030 rst asserted mid-transfer SHALL drop the transfer without raising proto_err.
- The foreign side sees ack fall and must restart.
REQ-031 After rst deasserts with req_async already high: a fresh capture per REQ-023.

Verification
REQ-032 Basic transfer, SYNC_STAGES=2, ready_in=1: data_async=0xA5, req_async rises -> valid_out on edge 3 with data_out=0xA5; ack=1 on edge 4; req drop -> ack=0 SYNC_STAGES+1 edges later; word_cnt=1.
REQ-033 Backpressure: ready_in=0 for 10 cycles after valid_out rises -> data_out and valid_out stable, ack=0 throughout; ready_in=1 -> ack=1 on the next edge.
REQ-034 Wrap: 256 back-to-back handshakes with data = index -> every word is delivered in order and word_cnt ends at 0.
REQ-035 Violation: req_async dropped while in HOLD -> proto_err=1; the word is still delivered; err_clr pulse -> proto_err=0; err_clr and a new violation on the same edge -> proto_err stays 1.
REQ-036 ena=0 with req_async high for 20 cycles -> no valid_out, ack=0; ena=1 -> valid_out 1 edge later.
REQ-037 rst pulse while in ACK -> ack=0, valid_out=0, word_cnt=0 immediately (asynchronously); a held-high req_async is re-captured per REQ-031.
